// File: rtl/pe_feeder_pkg.sv
// Shared types and default geometry for the PE feeder.
// Derived burst sizes are given here for the default 3x3 kernel over a 5x5 activation tile.
package pe_feeder_pkg;

    localparam int DEF_DATA_BITWIDTH = 16;
    localparam int DEF_KERNEL_SIZE   = 3;
    localparam int DEF_ACT_SIZE      = 5;

    localparam int N_WGHT    = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
    localparam int N_ACT     = DEF_ACT_SIZE * DEF_ACT_SIZE;
    localparam int N_ROWS    = DEF_ACT_SIZE - DEF_KERNEL_SIZE + 1;
    localparam int BUF_DEPTH = (N_WGHT > N_ACT) ? N_WGHT : N_ACT;
    localparam int BUF_PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [3:0] {
        IDLE,
        FILL_W,
        SEND_W,
        WAIT_WL,
        FILL_A,
        SEND_A,
        WAIT_AL,
        START,
        WAIT_CD,
        WAIT_CLR,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/pe_feeder_buf.sv
// Burst buffer: one synchronous write port, combinational read at rd_ptr.
// Contents are not reset; every word is written before it is read back.
module feed_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 25,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pe_feeder.sv
// Buffers one convolution job (weights then activations), replays each burst into the PE
// load ports without bubbles, then sequences one start per output row and drains results.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int ACT_SIZE      = DEF_ACT_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_BITWIDTH-1:0] filt_in,
    output logic [DATA_BITWIDTH-1:0] act_in,
    output logic                     load_en_wght,
    output logic                     load_en_act,
    output logic                     start,
    input  logic                     load_done,
    input  logic                     compute_done,
    input  logic [DATA_BITWIDTH-1:0] pe_out,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     job_done
);

    localparam int NUM_W    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NUM_A    = ACT_SIZE * ACT_SIZE;
    localparam int NUM_ROWS = ACT_SIZE - KERNEL_SIZE + 1;
    localparam int DEPTH    = (NUM_W > NUM_A) ? NUM_W : NUM_A;
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [PW-1:0] LAST_W   = PW'(NUM_W - 1);
    localparam logic [PW-1:0] LAST_A   = PW'(NUM_A - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

    state_t state, next_state;

    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [RW-1:0]            row;
    logic [DATA_BITWIDTH-1:0] rd_data;
    logic                     accept;
    logic                     out_fire;
    logic                     in_fill;
    logic                     in_send;

    logic in_ready_d;
    logic load_en_wght_d;
    logic load_en_act_d;
    logic start_d;
    logic out_valid_d;
    logic busy_d;
    logic job_done_d;

    // in_ready is registered from next_state, so it is high exactly while in a FILL state.
    assign accept   = in_ready && in_valid;
    assign out_fire = out_valid && out_ready;
    assign in_fill  = (state == FILL_W) || (state == FILL_A);
    assign in_send  = (state == SEND_W) || (state == SEND_A);

    feed_buf #(
        .WIDTH (DATA_BITWIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_ptr  (wr_ptr),
        .wr_data (in_data),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (in_valid)                      next_state = FILL_W;
            FILL_W:   if (accept && wr_ptr == LAST_W)    next_state = SEND_W;
            SEND_W:   if (rd_ptr == LAST_W)              next_state = WAIT_WL;
            WAIT_WL:  if (load_done)                     next_state = FILL_A;
            FILL_A:   if (accept && wr_ptr == LAST_A)    next_state = SEND_A;
            SEND_A:   if (rd_ptr == LAST_A)              next_state = WAIT_AL;
            WAIT_AL:  if (load_done)                     next_state = START;
            START:                                       next_state = WAIT_CD;
            WAIT_CD:  if (compute_done)                  next_state = WAIT_CLR;
            WAIT_CLR: if (!compute_done)                 next_state = OUT;
            OUT:      if (out_fire)                      next_state = (row == LAST_ROW) ? DONE : START;
            DONE:                                        next_state = IDLE;
            default:                                     next_state = IDLE;
        endcase
    end

    // Load enables follow the buffer read by one cycle so they line up with the registered data.
    always_comb begin
        in_ready_d     = (next_state == FILL_W) || (next_state == FILL_A);
        busy_d         = (next_state != IDLE);
        out_valid_d    = (next_state == OUT);
        start_d        = (next_state == START);
        job_done_d     = (next_state == DONE);
        load_en_wght_d = (state == SEND_W) && (rd_ptr == '0);
        load_en_act_d  = (state == SEND_A) && (rd_ptr == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready     <= 1'b0;
            filt_in      <= '0;
            act_in       <= '0;
            load_en_wght <= 1'b0;
            load_en_act  <= 1'b0;
            start        <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            job_done     <= 1'b0;
        end else begin
            in_ready     <= in_ready_d;
            load_en_wght <= load_en_wght_d;
            load_en_act  <= load_en_act_d;
            start        <= start_d;
            out_valid    <= out_valid_d;
            busy         <= busy_d;
            job_done     <= job_done_d;
            if (state == SEND_W) begin
                filt_in <= rd_data;
            end
            if (state == SEND_A) begin
                act_in <= rd_data;
            end
            if (state == WAIT_CD && compute_done) begin
                out_data <= pe_out;
            end
        end
    end

    // Pointers idle at zero, so each FILL and SEND starts from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            row    <= '0;
        end else begin
            if (!in_fill) begin
                wr_ptr <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (in_send) begin
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                rd_ptr <= '0;
            end

            if (state == IDLE) begin
                row <= '0;
            end else if (state == OUT && out_fire && row != LAST_ROW) begin
                row <= row + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a behavioural PE; everything runs in one process stepped on the falling edge.
module tb_pe_feeder;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] filt_in;
    logic [15:0] act_in;
    logic        load_en_wght;
    logic        load_en_act;
    logic        start;
    logic        load_done;
    logic        compute_done;
    logic [15:0] pe_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        job_done;

    int n_checks;
    int n_fail;
    int w_idx, a_idx, cd_wait, cd_left, cd_hold;
    int start_cnt, out_cnt, done_cnt, stall_cnt, first_accept_done;
    bit w_active, a_active, stall_en;
    logic [15:0] cd_val;

    pe_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .filt_in      (filt_in),
        .act_in       (act_in),
        .load_en_wght (load_en_wght),
        .load_en_act  (load_en_act),
        .start        (start),
        .load_done    (load_done),
        .compute_done (compute_done),
        .pe_out       (pe_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .job_done     (job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 20000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] word(input int i);
        return (i < 9) ? 16'(i + 1) : 16'(32'h0100 + i - 9);
    endfunction

    function automatic logic [15:0] resVal(input int r);
        return 16'(32'h0011 * (r + 1));
    endfunction

    // Behavioural PE plus output sink, evaluated once per falling edge.
    task automatic modelStep();
        if (!reset) begin
            w_active = 0; a_active = 0; w_idx = 0; a_idx = 0;
            cd_wait = 0; cd_left = 0; load_done = 0; compute_done = 0;
        end else begin
            load_done = 0;
            if (load_en_wght || load_en_act || start)
                checkOutput("pulse_exclusive", 32'(int'(load_en_wght) + int'(load_en_act) + int'(start)), 1);

            if (load_en_wght) begin
                checkOutput("wght_open_once", 32'(w_active), 0);
                w_active = 1; w_idx = 0;
            end
            if (w_active) begin
                checkOutput("filt_in_word", 32'(filt_in), 32'(word(w_idx)));
                w_idx++;
                if (w_idx == 9) begin w_active = 0; load_done = 1; end
            end

            if (load_en_act) begin
                checkOutput("act_open_once", 32'(a_active), 0);
                a_active = 1; a_idx = 0;
            end
            if (a_active) begin
                checkOutput("act_in_word", 32'(act_in), 32'(word(9 + a_idx)));
                a_idx++;
                if (a_idx == 25) begin a_active = 0; load_done = 1; end
            end

            if (start) begin
                checkOutput("start_cd_low", 32'(compute_done), 0);
                cd_val = resVal(start_cnt % 3);
                start_cnt++;
                cd_wait = 3;
            end
            if (cd_wait > 0) begin
                cd_wait--;
                if (cd_wait == 0) begin
                    compute_done = 1; pe_out = cd_val; cd_left = cd_hold;
                end
            end else if (compute_done) begin
                cd_left--;
                if (cd_left == 0) begin compute_done = 0; pe_out = 16'hdead; end
            end

            out_ready = !(stall_en && (out_cnt % 3 == 1) && stall_cnt < 20);
            if (out_valid && !out_ready) begin
                checkOutput("stall_data", 32'(out_data), 32'h0022);
                checkOutput("stall_no_start", 32'(start), 0);
                stall_cnt++;
            end
            if (out_valid && out_ready) begin
                checkOutput("out_data", 32'(out_data), 32'(resVal(out_cnt % 3)));
                out_cnt++;
            end
            if (job_done) done_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        modelStep();
    endtask

    task automatic checkResetValues();
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_filt_in", 32'(filt_in), 0);
        checkOutput("rst_act_in", 32'(act_in), 0);
        checkOutput("rst_load_en_wght", 32'(load_en_wght), 0);
        checkOutput("rst_load_en_act", 32'(load_en_act), 0);
        checkOutput("rst_start", 32'(start), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_job_done", 32'(job_done), 0);
    endtask

    // Sends the 34-word job; a word is taken at the rising edge following a falling edge with valid and ready high.
    task automatic applyStimulus(input bit gaps);
        int i = 0;
        int t = 0;
        first_accept_done = -1;
        while (i < 34 && t < 5000) begin
            tick();
            in_valid = gaps ? (t % 2 == 0) : 1'b1;
            in_data  = word(i);
            if (in_valid && in_ready) begin
                if (i == 0) first_accept_done = done_cnt;
                i++;
            end
            t++;
        end
        tick();
        in_valid = 1'b0;
        checkOutput("stim_words_sent", 32'(i), 34);
    endtask

    task automatic waitDone(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin
            tick();
            t++;
        end
        checkOutput("job_done_seen", 32'(done_cnt >= target), 1);
    endtask

    task automatic runJob(input bit gaps);
        int s0 = start_cnt;
        int o0 = out_cnt;
        int d0 = done_cnt;
        applyStimulus(gaps);
        waitDone(d0 + 1);
        checkOutput("job_starts", 32'(start_cnt - s0), 3);
        checkOutput("job_results", 32'(out_cnt - o0), 3);
        tick();
        checkOutput("job_done_pulse", 32'(job_done), 0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("job_done_count", 32'(done_cnt - d0), 1);
    endtask

    initial begin
        int d0, s0, o0, t;
        n_checks = 0; n_fail = 0;
        w_idx = 0; a_idx = 0; cd_wait = 0; cd_left = 0; cd_hold = 1;
        start_cnt = 0; out_cnt = 0; done_cnt = 0; stall_cnt = 0; first_accept_done = -1;
        w_active = 0; a_active = 0; stall_en = 0; cd_val = '0;
        reset = 1'b0; in_valid = 1'b0; in_data = '0;
        load_done = 1'b0; compute_done = 1'b0; pe_out = '0; out_ready = 1'b1;

        tick(); tick();
        checkResetValues();
        reset = 1'b1;
        tick();

        $display("[TB] nominal job");
        runJob(0);

        $display("[TB] upstream gaps");
        runJob(1);

        $display("[TB] downstream stall on row 1");
        stall_en = 1; stall_cnt = 0;
        runJob(0);
        checkOutput("stall_cycles", 32'(stall_cnt), 20);
        stall_en = 0;

        $display("[TB] sticky compute_done");
        cd_hold = 5;
        runJob(0);
        cd_hold = 1;

        $display("[TB] reset during activation burst");
        d0 = done_cnt;
        applyStimulus(0);
        t = 0;
        while (!(a_active && a_idx == 13) && t < 200) begin
            tick();
            t++;
        end
        checkOutput("reached_act_word_12", 32'(a_active && a_idx == 13), 1);
        reset = 1'b0;
        #1;
        checkResetValues();
        tick(); tick();
        reset = 1'b1;
        checkOutput("aborted_no_done", 32'(done_cnt - d0), 0);
        tick();
        runJob(0);

        $display("[TB] back-to-back jobs");
        d0 = done_cnt; s0 = start_cnt; o0 = out_cnt;
        applyStimulus(0);
        applyStimulus(0);
        checkOutput("b2b_second_after_done", 32'(first_accept_done), 32'(d0 + 1));
        waitDone(d0 + 2);
        checkOutput("b2b_starts", 32'(start_cnt - s0), 6);
        checkOutput("b2b_results", 32'(out_cnt - o0), 6);
        checkOutput("b2b_done_count", 32'(done_cnt - d0), 2);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
